// File: rtl/sec_encoder_24bits_clk.sv
// Bit-serial Hamming(29,24) SEC encoder: one data bit per cycle, codeword valid 24 edges after accept.
// Optional SEC_OVERALL_PARITY_EN adds even overall parity in W[29]; holds W/out_valid until out_ready.
module sec_encoder_24bits_clk #(
    parameter int D_BITS = 24,
    parameter int W_BITS = 32,
    parameter int P_BITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [D_BITS-1:0] D,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic              busy
);
    localparam int N_POS = D_BITS + P_BITS;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

    state_t              r_state;
    logic [D_BITS-1:0]   r_dreg;
    logic [P_BITS-1:0]   r_cnt;
    logic [P_BITS-1:0]   r_pos;
    logic [P_BITS-1:0]   r_acc;
    logic [W_BITS-1:0]   r_w;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [P_BITS-1:0]   w_pos_inc;
    logic [P_BITS-1:0]   w_pos_next;
    logic [P_BITS-1:0]   w_acc_next;
    logic [D_BITS-1:0]   w_d_orig;
    logic [N_POS-1:0]    w_code;
    logic [W_BITS-1:0]   w_code_full;

    // Position counter skips powers of two, which are reserved for check bits.
    assign w_pos_inc  = r_pos + P_BITS'(1);
    assign w_pos_next = ((w_pos_inc & (w_pos_inc - P_BITS'(1))) == '0) ? r_pos + P_BITS'(2) : w_pos_inc;
    assign w_acc_next = r_acc ^ (r_dreg[0] ? r_pos : '0);

    // The data register rotates; one more rotation on the last edge restores the captured word.
    assign w_d_orig = {r_dreg[0], r_dreg[D_BITS-1:1]};

    for (genvar p = 1; p <= N_POS; p++) begin : g_map
        if ((p & (p - 1)) == 0) begin : g_chk
            assign w_code[p-1] = w_acc_next[$clog2(p)];
        end else begin : g_dat
            assign w_code[p-1] = w_d_orig[p-1-$clog2(p)];
        end
    end

    assign w_code_full[N_POS-1:0] = w_code;
    assign w_code_full[W_BITS-1:N_POS+1] = '0;
`ifdef SEC_OVERALL_PARITY_EN
    assign w_code_full[N_POS] = ^w_code;
`else
    assign w_code_full[N_POS] = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dreg      <= '0;
            r_cnt       <= '0;
            r_pos       <= '0;
            r_acc       <= '0;
            r_w         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dreg     <= D;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_pos      <= P_BITS'(3);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_cnt > P_BITS'(D_BITS - 1)) begin
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_dreg <= {r_dreg[0], r_dreg[D_BITS-1:1]};
                        r_acc  <= w_acc_next;
                        r_pos  <= w_pos_next;
                        r_cnt  <= r_cnt + P_BITS'(1);
                        if (r_cnt == P_BITS'(D_BITS - 1)) begin
                            r_w         <= w_code_full;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign W         = r_w;
endmodule

// File: tb/tb_sec_encoder_24bits_clk.sv
// Self-checking bench for sec_encoder_24bits_clk against a position-list Hamming model.
module tb_sec_encoder_24bits_clk;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] D;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] W;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sec_encoder_24bits_clk dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .W         (W),
        .busy      (busy)
    );

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Data bits take the non-power-of-two positions in order; check bit 2^k = bit k of XOR of set positions.
    function automatic logic [31:0] ref_encode(input logic [23:0] d);
        logic [31:0] w = '0;
        int s = 0;
        int j = 0;
        for (int p = 1; p <= 29; p++) begin
            if (!is_pow2(p)) begin
                w[p-1] = d[j];
                if (d[j]) s = s ^ p;
                j++;
            end
        end
        for (int k = 0; k < 5; k++) w[(1 << k) - 1] = s[k];
`ifdef SEC_OVERALL_PARITY_EN
        w[29] = ^w[28:0];
`endif
        return w;
    endfunction

    function automatic int ref_syndrome(input logic [31:0] w);
        int s = 0;
        for (int p = 1; p <= 29; p++) if (w[p-1]) s = s ^ p;
        return s;
    endfunction

    function automatic logic [23:0] ref_extract(input logic [31:0] w);
        logic [23:0] d = '0;
        int j = 0;
        for (int p = 1; p <= 29; p++) begin
            if (!is_pow2(p)) begin
                d[j] = w[p-1];
                j++;
            end
        end
        return d;
    endfunction

    // Drives one word through accept and hand-off; lat = -1 on any timeout.
    task automatic do_encode(input logic [23:0] d, output logic [31:0] w, output int lat);
        int n = 0;
        lat = -1;
        w   = '0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) return;
        in_valid = 1'b1;
        D        = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        D        = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) return;
        w = W;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (W !== 32'h0)        begin bad++; $display("FAIL reset_W got=%h exp=0", W); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_out_ready got=v%b r%b b%b exp=v0 r1 b0", out_valid, in_ready, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_basic();
        logic [23:0] vec [3] = '{24'h000000, 24'h000001, 24'hFFFFFF};
        logic [31:0] w;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_encode(vec[i], w, lat);
            total++; if (lat != 24) begin bad++; $display("FAIL basic_latency d=%h got=%0d exp=24", vec[i], lat); end
            total++; if (w !== ref_encode(vec[i])) begin bad++; $display("FAIL basic_W d=%h got=%h exp=%h", vec[i], w, ref_encode(vec[i])); end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] w;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        D        = 24'h00000F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL calc_flags got=b%b r%b exp=b1 r0", busy, in_ready); end
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || W !== 32'h0) begin
            bad++; $display("FAIL midcalc_reset got=r%b v%b b%b W=%h exp=r1 v0 b0 W=0", in_ready, out_valid, busy, W);
        end
        @(negedge clk);
        rst = 1'b0;
        do_encode(24'h00000F, w, lat);
        total++; if (lat != 24 || w !== ref_encode(24'h00000F)) begin
            bad++; $display("FAIL after_reset_encode got=%h lat=%0d exp=%h lat=24", w, lat, ref_encode(24'h00000F));
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] d = 24'($urandom);
        logic [31:0] exp = ref_encode(d);
        logic [31:0] w;
        int lat = -1;
        @(negedge clk);
        in_valid = 1'b1;
        D        = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = i; break; end
        end
        total++; if (lat != 24) begin bad++; $display("FAIL bp_latency got=%0d exp=24", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 3);
            D        = $urandom;
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || W !== exp) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=v%b r%b W=%h exp=v1 r0 W=%h", i, out_valid, in_ready, W, exp);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || W !== exp) begin
            bad++; $display("FAIL bp_release got=v%b r%b b%b W=%h exp=v0 r1 b0 W=%h", out_valid, in_ready, busy, W, exp);
        end
        d = 24'($urandom);
        do_encode(d, w, lat);
        total++; if (lat != 24 || w !== ref_encode(d)) begin
            bad++; $display("FAIL bp_next got=%h lat=%0d exp=%h lat=24", w, lat, ref_encode(d));
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] q[$];
        int acc_cyc[$];
        int n_out = 0;
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 80);
            D        = $urandom;
            if (in_valid && in_ready) begin
                q.push_back(D);
                acc_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                n_out++;
                if (q.size() == 0) begin
                    total++; bad++; $display("FAIL b2b_spurious got=W%h exp=no output", W);
                end else begin
                    exp = ref_encode(q.pop_front());
                    total++; if (W !== exp) begin bad++; $display("FAIL b2b_W got=%h exp=%h", W, exp); end
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (n_out != 4 || q.size() != 0) begin bad++; $display("FAIL b2b_count got=%0d left=%0d exp=4 left=0", n_out, q.size()); end
        total++; if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 26) begin
            bad++; $display("FAIL b2b_interval got=%0d exp=26", (acc_cyc.size() < 2) ? -1 : acc_cyc[1] - acc_cyc[0]);
        end
    endtask

    task automatic test_loopback();
        logic [23:0] d;
        logic [31:0] w;
        logic [31:0] rx;
        int lat;
        int b;
        int syn;
        for (int n = 0; n < 1000; n++) begin
            d = 24'($urandom);
            do_encode(d, w, lat);
            total++; if (lat != 24 || w !== ref_encode(d)) begin
                bad++; $display("FAIL loop_W n=%0d got=%h lat=%0d exp=%h lat=24", n, w, lat, ref_encode(d));
            end
            b = $urandom_range(0, 28);
            rx = w ^ (32'h1 << b);
            syn = ref_syndrome(rx);
            total++; if (syn != b + 1) begin bad++; $display("FAIL loop_location n=%0d got=%0d exp=%0d", n, syn, b + 1); end
            if (syn >= 1 && syn <= 29) rx[syn-1] = ~rx[syn-1];
            total++; if (ref_extract(rx) !== d) begin bad++; $display("FAIL loop_data n=%0d got=%h exp=%h", n, ref_extract(rx), d); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_calc();
        test_backpressure();
        test_back_to_back();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
